// File: rtl/rr_burst_arbiter_if.sv
// Request/grant bundle between the round-robin burst arbiter (master side)
// and its N clients (slave side).
interface rr_burst_arbiter_if #(
  parameter int N   = 4,
  parameter int IDW = 2
) ();
  logic [N-1:0]   req;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           busy;
  logic           expired;

  modport master (
    input  req,
    output gnt, gnt_id, busy, expired
  );

  modport slave (
    output req,
    input  gnt, gnt_id, busy, expired
  );
endinterface

// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter with registered one-hot grant, burst cap of MAX_BURST
// cycles per tenure and a mandatory one-cycle turnaround between grants.
module rr_burst_arbiter #(
  parameter int N         = 4,
  parameter int IDW       = 2,
  parameter int MAX_BURST = 8,
  parameter int CNT_W     = 4
) (
  input  logic                clk,
  input  logic                n_rst,
  rr_burst_arbiter_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  localparam logic [IDW:0]     N_W      = (IDW+1)'(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  state_t           state_q, state_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             exp_q, exp_d;

  // Rotate requests so the pointer's client sits at bit 0; the lowest set
  // bit of the rotated vector is then the next client in round-robin order.
  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;
  logic           pick_valid;
  logic [IDW-1:0] pick_off;
  logic [IDW:0]   pick_sum;
  logic [IDW-1:0] pick_id;
  logic [IDW:0]   ptr_sum;
  logic [IDW-1:0] ptr_inc;

  assign req_dbl = {bus.req, bus.req};
  assign req_rot = N'(req_dbl >> ptr_q);

  always_comb begin
    pick_valid = 1'b0;
    pick_off   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        pick_valid = 1'b1;
        pick_off   = IDW'(k);
      end
    end
  end

  assign pick_sum = {1'b0, ptr_q} + {1'b0, pick_off};
  assign pick_id  = (pick_sum >= N_W) ? IDW'(pick_sum - N_W) : IDW'(pick_sum);

  // Priority moves to the client just after the one leaving GRANT.
  assign ptr_sum = {1'b0, id_q} + (IDW+1)'(1);
  assign ptr_inc = (ptr_sum == N_W) ? '0 : IDW'(ptr_sum);

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    exp_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = GRANT;
          gnt_d   = N'(1) << pick_id;
          id_d    = pick_id;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (!bus.req[id_q]) begin
          state_d = TURN;
          gnt_d   = '0;
          id_d    = '0;
          ptr_d   = ptr_inc;
        end else if (cnt_q == CNT_LAST) begin
          state_d = TURN;
          gnt_d   = '0;
          id_d    = '0;
          ptr_d   = ptr_inc;
          exp_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      TURN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        id_d    = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      exp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_id  = id_q;
  assign bus.busy    = (state_q == GRANT);
  assign bus.expired = exp_q;

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Self-checking bench for rr_burst_arbiter: directed vector table, hand-written
// multi-cycle sequences, and random traffic against a tenure-level model.
module tb_rr_burst_arbiter;

  logic       clk;
  logic       n_rst;
  logic [3:0] req_drv;

  int errors = 0;
  int checks = 0;

  rr_burst_arbiter_if #(.N(4), .IDW(2)) bus0 ();
  rr_burst_arbiter_if #(.N(4), .IDW(2)) bus1 ();

  assign bus0.req = req_drv;
  assign bus1.req = req_drv;

  rr_burst_arbiter #(.N(4), .IDW(2), .MAX_BURST(8), .CNT_W(4)) dut0 (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus0)
  );

  rr_burst_arbiter #(.N(4), .IDW(2), .MAX_BURST(1), .CNT_W(1)) dut1 (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: who owns the resource, for how many cycles so far, whether the
  // turnaround gap is in progress, and whose turn is next.
  typedef struct {
    int owner;
    int held;
    bit turn;
    int ptr;
    bit expired;
  } model_t;

  model_t m0, m1;

  function automatic model_t model_next(model_t m, bit rst_n, logic [3:0] r, int mb);
    model_t n;
    bit     found;
    int     c;
    n = m;
    n.expired = 1'b0;
    found = 1'b0;
    if (!rst_n) begin
      n.owner = -1;
      n.held  = 0;
      n.turn  = 1'b0;
      n.ptr   = 0;
    end else if (m.owner >= 0) begin
      if (r[m.owner[1:0]] == 1'b0 || m.held >= mb) begin
        n.expired = r[m.owner[1:0]];
        n.owner   = -1;
        n.held    = 0;
        n.turn    = 1'b1;
        n.ptr     = (m.owner + 1) % 4;
      end else begin
        n.held = m.held + 1;
      end
    end else if (m.turn) begin
      n.turn = 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        c = (m.ptr + k) % 4;
        if (!found && r[c[1:0]]) begin
          found   = 1'b1;
          n.owner = c;
          n.held  = 1;
        end
      end
    end
    return n;
  endfunction

  function automatic logic [3:0] m_gnt(model_t m);
    return (m.owner >= 0) ? (4'b0001 << m.owner) : 4'b0000;
  endfunction

  function automatic logic [1:0] m_id(model_t m);
    return (m.owner >= 0) ? m.owner[1:0] : 2'd0;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(bit rst_n, logic [3:0] r);
    n_rst   = rst_n;
    req_drv = r;
    @(posedge clk);
    #1;
    m0 = model_next(m0, rst_n, r, 8);
    m1 = model_next(m1, rst_n, r, 1);
  endtask

  task automatic check_model(string tag);
    check({tag, " gnt0"},  32'(bus0.gnt),     32'(m_gnt(m0)));
    check({tag, " id0"},   32'(bus0.gnt_id),  32'(m_id(m0)));
    check({tag, " busy0"}, 32'(bus0.busy),    32'(m0.owner >= 0));
    check({tag, " exp0"},  32'(bus0.expired), 32'(m0.expired));
    check({tag, " gnt1"},  32'(bus1.gnt),     32'(m_gnt(m1)));
    check({tag, " id1"},   32'(bus1.gnt_id),  32'(m_id(m1)));
    check({tag, " busy1"}, 32'(bus1.busy),    32'(m1.owner >= 0));
    check({tag, " exp1"},  32'(bus1.expired), 32'(m1.expired));
  endtask

  typedef struct {
    bit         rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] id;
    bit         busy;
    bit         expired;
  } vec_t;

  vec_t vecs[14];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p, t;
    logic [3:0] r;
    bit rn;

    n_rst   = 1'b0;
    req_drv = 4'b0000;
    m0 = '{owner: -1, held: 0, turn: 1'b0, ptr: 0, expired: 1'b0};
    m1 = m0;

    // Reset hold, release into a grant, short request, pointer advance.
    vecs[0]  = '{1'b0, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 4'b0100, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 4'b1111, 4'b1000, 2'd3, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};

    foreach (vecs[i]) begin
      step(vecs[i].rst_n, vecs[i].req);
      check($sformatf("vec%0d gnt", i),  32'(bus0.gnt),     32'(vecs[i].gnt));
      check($sformatf("vec%0d id", i),   32'(bus0.gnt_id),  32'(vecs[i].id));
      check($sformatf("vec%0d busy", i), 32'(bus0.busy),    32'(vecs[i].busy));
      check($sformatf("vec%0d exp", i),  32'(bus0.expired), 32'(vecs[i].expired));
    end

    // Sole persistent requester: 8 on / 2 off, and 1 on / 2 off when MAX_BURST=1.
    step(1'b0, 4'b0000);
    for (int c = 1; c <= 30; c++) begin
      step(1'b1, 4'b0010);
      p = (c - 1) % 10;
      check($sformatf("sole c%0d gnt", c), 32'(bus0.gnt),     (p < 8) ? 32'd2 : 32'd0);
      check($sformatf("sole c%0d exp", c), 32'(bus0.expired), (p == 8) ? 32'd1 : 32'd0);
      p = (c - 1) % 3;
      check($sformatf("sole1 c%0d gnt", c), 32'(bus1.gnt),     (p == 0) ? 32'd2 : 32'd0);
      check($sformatf("sole1 c%0d exp", c), 32'(bus1.expired), (p == 1) ? 32'd1 : 32'd0);
    end

    // All clients requesting: owners 0,1,2,3,0, each 8 cycles, 2-cycle gaps.
    step(1'b0, 4'b0000);
    for (int c = 1; c <= 50; c++) begin
      step(1'b1, 4'b1111);
      p = (c - 1) % 10;
      t = (c - 1) / 10;
      check($sformatf("rr c%0d gnt", c), 32'(bus0.gnt),
            (p < 8) ? (32'd1 << (t % 4)) : 32'd0);
      check($sformatf("rr c%0d id", c), 32'(bus0.gnt_id),
            (p < 8) ? 32'(t % 4) : 32'd0);
      check($sformatf("rr c%0d exp", c), 32'(bus0.expired), (p == 8) ? 32'd1 : 32'd0);
    end

    // Reset in the middle of a grant: no expiry pulse, pointer back to 0.
    step(1'b0, 4'b0000);
    for (int c = 1; c <= 3; c++) begin
      step(1'b1, 4'b0010);
      check($sformatf("midrst c%0d gnt", c), 32'(bus0.gnt), 32'd2);
    end
    step(1'b0, 4'b0010);
    check("midrst rst gnt",  32'(bus0.gnt),     32'd0);
    check("midrst rst exp",  32'(bus0.expired), 32'd0);
    check("midrst rst busy", 32'(bus0.busy),    32'd0);
    step(1'b1, 4'b0011);
    check("midrst regrant gnt", 32'(bus0.gnt),    32'd1);
    check("midrst regrant id",  32'(bus0.gnt_id), 32'd0);

    // Wrap from client 3 back to client 0.
    step(1'b0, 4'b0000);
    step(1'b1, 4'b0100);
    check("wrap gnt2", 32'(bus0.gnt), 32'd4);
    step(1'b1, 4'b0000);
    check("wrap rel", 32'(bus0.gnt), 32'd0);
    step(1'b1, 4'b1001);
    check("wrap turn", 32'(bus0.gnt), 32'd0);
    step(1'b1, 4'b1001);
    check("wrap gnt3", 32'(bus0.gnt),    32'd8);
    check("wrap id3",  32'(bus0.gnt_id), 32'd3);
    for (int c = 2; c <= 8; c++) begin
      step(1'b1, 4'b1001);
      check($sformatf("wrap hold%0d", c), 32'(bus0.gnt), 32'd8);
    end
    step(1'b1, 4'b1001);
    check("wrap expire gnt", 32'(bus0.gnt),     32'd0);
    check("wrap expire exp", 32'(bus0.expired), 32'd1);
    step(1'b1, 4'b1001);
    check("wrap gap exp", 32'(bus0.expired), 32'd0);
    step(1'b1, 4'b1001);
    check("wrap gnt0", 32'(bus0.gnt),    32'd1);
    check("wrap id0",  32'(bus0.gnt_id), 32'd0);

    // Random traffic with sticky requests and occasional resets.
    step(1'b0, 4'b0000);
    r = 4'b0000;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      rn = ($urandom_range(0, 199) != 0);
      step(rn, r);
      check_model($sformatf("rand c%0d", c));
      check($sformatf("rand c%0d onehot", c), 32'($countones(bus0.gnt) <= 1), 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
